mio_bus_responder: RTL and testbench
====================================

# mio_bus_responder

Memory/IO responder on the CPU memory bus. Each multicycle-CPU access arrives as mem_r/mem_w with addr_bus and Cpu_data2bus. The block decodes the address to on-chip RAM, the GPIO register, or unmapped space, and sequences RAM wait states. It returns read data on Cpu_data4bus and signals completion on MIO_ready, which gates PC/IR updates in the CPU.

## Interface
- RAM_AW, 10: RAM word-address width (1024 words).
- RAM_LAT, 1: RAM read latency in cycles, legal 1..4.
- GPIO_W, 16: GPIO output/switch width.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_r  in  1  read request; held until MIO_ready.
- mem_w  in  1  write request; held until MIO_ready.
- addr_bus  in  32  byte address; bits [1:0] ignored.
- Cpu_data2bus  in  32  write data.
- Cpu_data4bus  out  32  read data.
- MIO_ready  out  1  bus idle or transaction complete.
- bus_err  out  1  one-cycle pulse: unmapped access completed.
- ram_addr  out  RAM_AW  RAM word address.
- ram_din  out  32  RAM write data.
- ram_we  out  1  RAM write strobe.
- ram_dout  in  32  RAM read data.
- gpio_out  out  GPIO_W  GPIO output register.
- switches  in  GPIO_W  switch inputs.

## Operation
- Decode: addr_bus[31:28]==4'h0 → RAM, word index addr_bus[RAM_AW+1:2]. addr_bus[31:28]==4'hE → GPIO. Anything else → unmapped.
- FSM states: IDLE, BUSY, DONE.
- IDLE, no request: MIO_ready=1.
- IDLE, mem_r|mem_w: accept. Latch address, write data, region and direction; go to BUSY. MIO_ready=0 in the accept cycle.
- Both mem_r and mem_w asserted: treated as a write.
- BUSY, RAM region: lasts RAM_LAT+1 cycles, tracked by a down-counter.
  - ram_addr is held for the whole of BUSY.
  - Write: ram_we=1 in the first BUSY cycle only.
  - Read: ram_dout is captured in the last BUSY cycle.
- BUSY, GPIO or unmapped region: lasts exactly 1 cycle.
  - GPIO write loads gpio_out from Cpu_data2bus[GPIO_W-1:0].
  - GPIO read captures {zero-extend, switches}.
  - Unmapped: write ignored; read captures 32'h0.
- DONE: MIO_ready=1 for one cycle; bus_err=1 if the access was unmapped. Always returns to IDLE.
- A request still asserted in the following IDLE cycle is a new transaction (back-to-back allowed).
- Cpu_data4bus holds the last captured read value until the next read capture. Writes do not change it.
- Reset values, including reset mid-transaction: state IDLE, MIO_ready=1, Cpu_data4bus=0, bus_err=0, ram_we=0, ram_addr=0, ram_din=0, gpio_out=0. A pending write is dropped and ram_we is never issued after reset.

## Timing
- The accept cycle is T. BUSY begins at T+1.
- RAM read: ram_addr is presented at T+1. ram_dout is valid at T+1+RAM_LAT and captured at the end of that cycle. DONE/ready at T+2+RAM_LAT.
- RAM write: ram_we is high at T+1 only. DONE at T+2+RAM_LAT (uniform latency).
- GPIO/unmapped: the gpio_out update is visible at T+2. DONE at T+2.
- MIO_ready is 0 from the accept cycle T through the last BUSY cycle. It is a registered function of state and a combinational function of request in IDLE only.
- Address and data changes during BUSY are ignored, because the latched copies are used.

## Structure
- Package mio_pkg holds:
  - region base constants RAM_BASE_NIB=4'h0 and GPIO_BASE_NIB=4'hE;
  - the region enum {REG_RAM, REG_GPIO, REG_NONE};
  - the FSM state enum.
- One combinational sub-module, mio_addr_decode: addr_bus → region.
- FSM, counter and registers stay in the top module.

## Test plan
- Reset then idle: rst high 2 cycles → MIO_ready=1, gpio_out=0, Cpu_data4bus=0, ram_we never high.
- RAM write/read, RAM_LAT=1:
  - Write 0xDEADBEEF to 0x0000_0010 → ram_we for exactly one cycle with ram_addr=4, ready at T+3.
  - Read the same address → Cpu_data4bus=0xDEADBEEF at T+3.
- GPIO: write 0x0000_A5A5 to 0xE000_0000 → gpio_out=16'hA5A5 at T+2. With switches=16'h1234, a read returns 0x0000_1234.
- Unmapped: read 0x8000_0000 → Cpu_data4bus=0 and bus_err pulses 1 cycle at T+2. A write there leaves RAM and gpio_out unchanged.
- Boundaries:
  - RAM_LAT=4 read: ready at T+6.
  - mem_r and mem_w together: treated as a write.
  - Back-to-back requests are each accepted, one DONE per request.
  - rst asserted in the first BUSY cycle of a RAM write: no ram_we, state IDLE next cycle.

Source files
------------

// File: rtl/mio_bus_responder_pkg.sv
// Shared types for the CPU memory/IO responder: region decode constants,
// the decoded region, FSM states and the latched request payload.
package mio_pkg;

    localparam int unsigned BUS_W = 32;

    localparam logic [3:0] RAM_BASE_NIB  = 4'h0;
    localparam logic [3:0] GPIO_BASE_NIB = 4'hE;

    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_GPIO = 2'd1,
        REG_NONE = 2'd2
    } region_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Request captured in the accept cycle; later bus changes are ignored.
    typedef struct packed {
        logic             is_wr;
        region_e          region;
        logic [BUS_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/mio_bus_responder_if.sv
// CPU-side memory bus: request/address/data from the CPU, read data and
// completion back from the responder.
interface mio_bus_responder_if;

    localparam int unsigned BUS_W = 32;

    logic             mem_r;
    logic             mem_w;
    logic [BUS_W-1:0] addr_bus;
    logic [BUS_W-1:0] Cpu_data2bus;
    logic [BUS_W-1:0] Cpu_data4bus;
    logic             MIO_ready;
    logic             bus_err;

    modport master (
        output mem_r, mem_w, addr_bus, Cpu_data2bus,
        input  Cpu_data4bus, MIO_ready, bus_err
    );

    modport slave (
        input  mem_r, mem_w, addr_bus, Cpu_data2bus,
        output Cpu_data4bus, MIO_ready, bus_err
    );

endinterface

// File: rtl/mio_bus_responder_addr_decode.sv
// Maps the top address nibble onto the RAM, GPIO or unmapped region.
module mio_addr_decode
    import mio_pkg::*;
(
    input  logic [3:0] addr_nib_i,
    output region_e    region_o
);

    always_comb begin
        region_o = REG_NONE;
        if (addr_nib_i == RAM_BASE_NIB) begin
            region_o = REG_RAM;
        end else if (addr_nib_i == GPIO_BASE_NIB) begin
            region_o = REG_GPIO;
        end
    end

endmodule

// File: rtl/mio_bus_responder.sv
// Memory/IO responder: decodes CPU accesses to RAM, GPIO or unmapped space,
// sequences RAM wait states and reports completion through MIO_ready.
module mio_bus_responder
    import mio_pkg::*;
#(
    parameter int unsigned RAM_AW  = 10,
    parameter int unsigned RAM_LAT = 1,
    parameter int unsigned GPIO_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    mio_bus_responder_if.slave  bus,
    output logic [RAM_AW-1:0]   ram_addr,
    output logic [BUS_W-1:0]    ram_din,
    output logic                ram_we,
    input  logic [BUS_W-1:0]    ram_dout,
    output logic [GPIO_W-1:0]   gpio_out,
    input  logic [GPIO_W-1:0]   switches
);

    localparam int unsigned CNT_W = 3;

    state_e             state_q;
    req_t               req_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [RAM_AW-1:0]  ram_addr_q;
    logic               ram_we_q;
    logic [BUS_W-1:0]   rdata_q;
    logic               bus_err_q;
    logic [GPIO_W-1:0]  gpio_q;

    region_e            region_d;
    logic               req_d;
    logic               unused_addr;

    assign req_d       = bus.mem_r | bus.mem_w;
    assign unused_addr = ^{bus.addr_bus[1:0], bus.addr_bus[27:RAM_AW+2]};

    mio_addr_decode u_addr_decode (
        .addr_nib_i (bus.addr_bus[31:28]),
        .region_o   (region_d)
    );

    // Sequencer: accept in IDLE, count RAM wait states in BUSY, one DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            req_q      <= '{is_wr: 1'b0, region: REG_NONE, wdata: '0};
            cnt_q      <= '0;
            ram_addr_q <= '0;
            ram_we_q   <= 1'b0;
            rdata_q    <= '0;
            bus_err_q  <= 1'b0;
            gpio_q     <= '0;
        end else begin
            ram_we_q  <= 1'b0;
            bus_err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_d) begin
                        state_q      <= BUSY;
                        req_q.is_wr  <= bus.mem_w;
                        req_q.region <= region_d;
                        req_q.wdata  <= bus.Cpu_data2bus;
                        if (region_d == REG_RAM) begin
                            ram_addr_q <= bus.addr_bus[RAM_AW+1:2];
                            ram_we_q   <= bus.mem_w;
                            cnt_q      <= CNT_W'(RAM_LAT);
                        end else begin
                            cnt_q <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        state_q   <= DONE;
                        bus_err_q <= (req_q.region == REG_NONE);
                        unique case (req_q.region)
                            REG_RAM: begin
                                if (!req_q.is_wr) rdata_q <= ram_dout;
                            end
                            REG_GPIO: begin
                                if (req_q.is_wr) gpio_q  <= req_q.wdata[GPIO_W-1:0];
                                else             rdata_q <= BUS_W'(switches);
                            end
                            default: begin
                                if (!req_q.is_wr) rdata_q <= '0;
                            end
                        endcase
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Ready is combinational on the request only while idle.
    assign bus.MIO_ready    = (state_q == IDLE) ? ~req_d : (state_q == DONE);
    assign bus.Cpu_data4bus = rdata_q;
    assign bus.bus_err      = bus_err_q;

    // A reset landing on the strobe cycle must still suppress the write.
    assign ram_we   = ram_we_q & ~rst;
    assign ram_addr = ram_addr_q;
    assign ram_din  = req_q.wdata;
    assign gpio_out = gpio_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Self-checking bench: a transaction-schedule model checks instance A
// (RAM_LAT=1) every cycle; directed literal checks cover A and B (RAM_LAT=4).
module tb_mio_bus_responder;

    localparam int unsigned AW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    mio_bus_responder_if bus_a();
    mio_bus_responder_if bus_b();

    logic [AW-1:0] ram_addr_a, ram_addr_b;
    logic [31:0]   ram_din_a, ram_din_b, ram_dout_a, ram_dout_b;
    logic          ram_we_a, ram_we_b;
    logic [15:0]   gpio_a, gpio_b;
    logic [15:0]   sw = 16'h1234;

    mio_bus_responder #(.RAM_AW(AW), .RAM_LAT(1), .GPIO_W(16)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave),
        .ram_addr(ram_addr_a), .ram_din(ram_din_a), .ram_we(ram_we_a),
        .ram_dout(ram_dout_a), .gpio_out(gpio_a), .switches(sw)
    );

    mio_bus_responder #(.RAM_AW(AW), .RAM_LAT(4), .GPIO_W(16)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave),
        .ram_addr(ram_addr_b), .ram_din(ram_din_b), .ram_we(ram_we_b),
        .ram_dout(ram_dout_b), .gpio_out(gpio_b), .switches(sw)
    );

    // RAM for A: one-cycle registered read.
    logic [31:0] mem_a [1024] = '{default: 32'h0};
    logic [31:0] pipe_a = 32'h0;
    always @(posedge clk) begin
        if (ram_we_a) mem_a[ram_addr_a] <= ram_din_a;
        pipe_a <= mem_a[ram_addr_a];
    end
    assign ram_dout_a = pipe_a;

    // RAM for B: four-cycle pipelined read of a fixed address-derived pattern.
    logic [31:0] pipe_b [4] = '{default: 32'h0};
    always @(posedge clk) begin
        pipe_b[0] <= 32'hCAFE_0000 | 32'(ram_addr_b);
        for (int i = 1; i < 4; i++) pipe_b[i] <= pipe_b[i-1];
    end
    assign ram_dout_b = pipe_b[3];

    // Event counters on A.
    int          we_cnt  = 0;
    int          err_cnt = 0;
    logic [31:0] we_addr = 32'h0;
    always @(negedge clk) begin
        if (ram_we_a) begin
            we_cnt++;
            we_addr = 32'(ram_addr_a);
        end
        if (bus_a.bus_err) err_cnt++;
    end

    // Transaction-schedule model of A.
    bit          in_txn = 1'b0;
    bit          armed  = 1'b0;
    int          t_done, t_we;
    bit          m_wr;
    int          m_kind;
    logic [9:0]  m_word;
    logic [31:0] m_wdata;
    logic [31:0] exp_data = 32'h0;
    logic [15:0] exp_gpio = 16'h0;
    bit   [31:0] shadow [1024];

    always @(negedge clk) begin
        bit req, e_ready, e_we, e_err;
        if (rst) begin
            check("we_in_reset", 32'(ram_we_a), 32'h0);
            in_txn   = 1'b0;
            exp_data = 32'h0;
            exp_gpio = 16'h0;
            armed    = 1'b1;
        end else if (armed) begin
            req   = bus_a.mem_r | bus_a.mem_w;
            e_we  = 1'b0;
            e_err = 1'b0;
            if (in_txn) begin
                e_ready = (cyc == t_done);
                e_we    = (cyc == t_we);
                if (cyc == t_done) begin
                    case (m_kind)
                        0: if (m_wr) shadow[m_word] = m_wdata; else exp_data = shadow[m_word];
                        1: if (m_wr) exp_gpio = m_wdata[15:0]; else exp_data = {16'h0, sw};
                        default: begin
                            e_err = 1'b1;
                            if (!m_wr) exp_data = 32'h0;
                        end
                    endcase
                    in_txn = 1'b0;
                end
            end else begin
                e_ready = !req;
                if (req) begin
                    in_txn  = 1'b1;
                    m_wr    = bus_a.mem_w;
                    m_kind  = (bus_a.addr_bus[31:28] == 4'h0) ? 0 :
                              (bus_a.addr_bus[31:28] == 4'hE) ? 1 : 2;
                    m_word  = bus_a.addr_bus[11:2];
                    m_wdata = bus_a.Cpu_data2bus;
                    t_done  = cyc + 2 + ((m_kind == 0) ? 1 : 0);
                    t_we    = (m_kind == 0 && m_wr) ? cyc + 1 : -1;
                end
            end
            check("ready", 32'(bus_a.MIO_ready), 32'(e_ready));
            check("ram_we", 32'(ram_we_a), 32'(e_we));
            check("bus_err", 32'(bus_a.bus_err), 32'(e_err));
            check("rdata", bus_a.Cpu_data4bus, exp_data);
            check("gpio", 32'(gpio_a), 32'(exp_gpio));
            if (e_we) begin
                check("we_addr", 32'(ram_addr_a), 32'(m_word));
                check("we_din", ram_din_a, m_wdata);
            end
        end
    end

    task automatic req_a(input bit r, input bit w, input logic [31:0] addr, input logic [31:0] data,
                         input bit hold, output int lat);
        int t0;
        @(posedge clk); #1;
        bus_a.mem_r = r; bus_a.mem_w = w; bus_a.addr_bus = addr; bus_a.Cpu_data2bus = data;
        t0  = cyc;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus_a.MIO_ready && cyc > t0) begin
                lat = cyc - t0;
                break;
            end
        end
        if (!hold) begin
            @(posedge clk); #1;
            bus_a.mem_r = 1'b0; bus_a.mem_w = 1'b0;
        end
    endtask

    task automatic req_b(input logic [31:0] addr, output int lat);
        int t0;
        @(posedge clk); #1;
        bus_b.mem_r = 1'b1; bus_b.addr_bus = addr;
        t0  = cyc;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus_b.MIO_ready && cyc > t0) begin
                lat = cyc - t0;
                break;
            end
        end
        @(posedge clk); #1;
        bus_b.mem_r = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int lat, lat2, we0, err0;
        bus_a.mem_r = 1'b0; bus_a.mem_w = 1'b0; bus_a.addr_bus = 32'h0; bus_a.Cpu_data2bus = 32'h0;
        bus_b.mem_r = 1'b0; bus_b.mem_w = 1'b0; bus_b.addr_bus = 32'h0; bus_b.Cpu_data2bus = 32'h0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(bus_a.MIO_ready), 32'h1);
        check("rst_gpio", 32'(gpio_a), 32'h0);
        check("rst_rdata", bus_a.Cpu_data4bus, 32'h0);
        check("rst_ready_b", 32'(bus_b.MIO_ready), 32'h1);

        // RAM write then read back
        we0 = we_cnt;
        req_a(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, lat);
        check("ram_wr_lat", 32'(lat), 32'd3);
        check("ram_wr_pulses", 32'(we_cnt - we0), 32'd1);
        check("ram_wr_addr", we_addr, 32'd4);
        req_a(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0, lat);
        check("ram_rd_lat", 32'(lat), 32'd3);
        check("ram_rd_data", bus_a.Cpu_data4bus, 32'hDEAD_BEEF);

        // GPIO write and switch read
        req_a(1'b0, 1'b1, 32'hE000_0000, 32'h0000_A5A5, 1'b0, lat);
        check("gpio_wr_lat", 32'(lat), 32'd2);
        check("gpio_wr_val", 32'(gpio_a), 32'h0000_A5A5);
        req_a(1'b1, 1'b0, 32'hE000_0000, 32'h0, 1'b0, lat);
        check("gpio_rd_data", bus_a.Cpu_data4bus, 32'h0000_1234);

        // Unmapped read and write
        err0 = err_cnt;
        req_a(1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b0, lat);
        check("unm_rd_lat", 32'(lat), 32'd2);
        check("unm_rd_data", bus_a.Cpu_data4bus, 32'h0);
        check("unm_err_pulse", 32'(err_cnt - err0), 32'd1);
        we0 = we_cnt;
        req_a(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat);
        check("unm_wr_gpio", 32'(gpio_a), 32'h0000_A5A5);
        check("unm_wr_no_we", 32'(we_cnt - we0), 32'd0);
        req_a(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0, lat);
        check("ram_kept", bus_a.Cpu_data4bus, 32'hDEAD_BEEF);

        // Read and write together behave as a write
        we0 = we_cnt;
        req_a(1'b1, 1'b1, 32'h0000_0020, 32'h1111_2222, 1'b0, lat);
        check("rw_is_write", 32'(we_cnt - we0), 32'd1);
        check("rw_rdata_kept", bus_a.Cpu_data4bus, 32'hDEAD_BEEF);
        req_a(1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b0, lat);
        check("rw_readback", bus_a.Cpu_data4bus, 32'h1111_2222);

        // Back-to-back unmapped reads, request held across DONE
        err0 = err_cnt;
        req_a(1'b1, 1'b0, 32'h8000_0004, 32'h0, 1'b1, lat);
        req_a(1'b1, 1'b0, 32'h9000_0000, 32'h0, 1'b0, lat2);
        check("b2b_lat0", 32'(lat), 32'd2);
        check("b2b_lat1", 32'(lat2), 32'd2);
        check("b2b_errs", 32'(err_cnt - err0), 32'd2);

        // Reset in the first BUSY cycle of a RAM write
        we0 = we_cnt;
        @(posedge clk); #1;
        bus_a.mem_w = 1'b1; bus_a.addr_bus = 32'h0000_0030; bus_a.Cpu_data2bus = 32'h5555_5555;
        @(posedge clk); #1;
        rst = 1'b1; bus_a.mem_w = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", 32'(bus_a.MIO_ready), 32'h1);
        check("rst_mid_no_we", 32'(we_cnt - we0), 32'd0);
        check("rst_mid_mem", mem_a[12], 32'h0);
        req_a(1'b1, 1'b0, 32'h0000_0030, 32'h0, 1'b0, lat);
        check("rst_mid_readback", bus_a.Cpu_data4bus, 32'h0);

        // RAM_LAT=4 instance
        req_b(32'h0000_0040, lat);
        check("lat4_ready", 32'(lat), 32'd6);
        check("lat4_data", bus_b.Cpu_data4bus, 32'hCAFE_0010);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
